mem_access_unit: RTL and testbench

- MEM stage of the RV32I pipeline. Takes the EX-stage bundle (address in `result`, `write_data`, `align`, `memread`/`memwrite`, writeback controls).
- Runs load and store transactions on a word-wide data-memory bus with a req/ack handshake. Store data is lane-shifted and strobed. Load data is extracted and sign- or zero-extended.
- Delivers a registered writeback bundle to WB and stalls upstream while a transaction is outstanding.

---
 rtl/mem_pkg.sv | 44 ++++
 rtl/load_formatter.sv | 33 +++
 rtl/mem_access_unit.sv | 235 +++++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the MEM stage: funct3 size codes, FSM encoding and
// the access-legality check used at the point of acceptance.
package mem_pkg;

  localparam logic [2:0] MEM_B  = 3'b000;
  localparam logic [2:0] MEM_H  = 3'b001;
  localparam logic [2:0] MEM_W  = 3'b010;
  localparam logic [2:0] MEM_BU = 3'b100;
  localparam logic [2:0] MEM_HU = 3'b101;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  typedef enum logic [1:0] {
    ERR_NONE,
    ERR_MISALIGN,
    ERR_ILLEGAL,
    ERR_TIMEOUT
  } err_cause_e;

  // Direction bit in align[3] must agree with memwrite; a mismatch is treated as illegal.
  function automatic err_cause_e check_access(input logic       rd_en,
                                              input logic       wr_en,
                                              input logic       st_bit,
                                              input logic [2:0] f3,
                                              input logic [1:0] addr_lo);
    err_cause_e c;
    c = ERR_NONE;
    if ((rd_en && wr_en) || (st_bit != wr_en)) begin
      c = ERR_ILLEGAL;
    end else if (wr_en && !(f3 inside {MEM_B, MEM_H, MEM_W})) begin
      c = ERR_ILLEGAL;
    end else if (rd_en && !(f3 inside {MEM_B, MEM_H, MEM_W, MEM_BU, MEM_HU})) begin
      c = ERR_ILLEGAL;
    end else if ((f3 == MEM_H || f3 == MEM_HU) && addr_lo[0]) begin
      c = ERR_MISALIGN;
    end else if (f3 == MEM_W && addr_lo != 2'b00) begin
      c = ERR_MISALIGN;
    end
    return c;
  endfunction

endpackage

// File: rtl/load_formatter.sv
// Load data lane selection and sign/zero extension for the MEM stage.
module load_formatter
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr_lo)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    case (funct3)
      MEM_B:   data = {{24{byte_sel[7]}}, byte_sel};
      MEM_H:   data = {{16{half_sel[15]}}, half_sel};
      MEM_W:   data = rdata;
      MEM_BU:  data = {24'h0, byte_sel};
      MEM_HU:  data = {16'h0, half_sel};
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// RV32I MEM stage: runs loads/stores over a req/ack data bus, formats load
// data and hands a registered writeback bundle to WB.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic [31:0]       ex_result,
  input  logic [31:0]       ex_write_data,
  input  logic [3:0]        ex_align,
  input  logic              ex_memread,
  input  logic              ex_memwrite,
  input  logic              ex_memtoreg,
  input  logic              ex_regwrite,
  input  logic [4:0]        ex_rd_addr,
  output logic              stall,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  output logic [3:0]        dmem_wstrb,
  input  logic [31:0]       dmem_rdata,
  input  logic              dmem_ack,
  output logic              wb_valid,
  output logic [31:0]       wb_data,
  output logic [4:0]        wb_rd_addr,
  output logic              wb_regwrite,
  output logic              mem_err,
  output logic [31:0]       err_addr
);

  localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [1:0]       state_q,     state_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic [31:0]      addr_q,      addr_d;
  logic [2:0]       f3_q,        f3_d;
  logic             we_q,        we_d;
  logic [4:0]       rd_q,        rd_d;
  logic             regwrite_q,  regwrite_d;
  logic             memtoreg_q,  memtoreg_d;
  logic [31:0]      wdata_q,     wdata_d;
  logic [3:0]       wstrb_q,     wstrb_d;
  logic [31:0]      rdata_q,     rdata_d;
  logic             wb_valid_q,  wb_valid_d;
  logic [31:0]      wb_data_q,   wb_data_d;
  logic [4:0]       wb_rd_q,     wb_rd_d;
  logic             wb_regwr_q,  wb_regwr_d;
  logic             mem_err_q,   mem_err_d;
  logic [31:0]      err_addr_q,  err_addr_d;

  err_cause_e  access_cause;
  err_cause_e  err_cause;
  logic        is_mem;
  logic        busy;
  logic        timeout_hit;
  logic [31:0] load_data;

  load_formatter u_load_formatter (
    .rdata   (rdata_q),
    .addr_lo (addr_q[1:0]),
    .funct3  (f3_q),
    .data    (load_data)
  );

  assign is_mem       = ex_memread | ex_memwrite;
  assign access_cause = check_access(ex_memread, ex_memwrite, ex_align[3],
                                     ex_align[2:0], ex_result[1:0]);
  assign busy         = (state_q == ST_BUSY);
  // cnt_q counts completed BUSY cycles, so the current cycle is number cnt_q+1.
  assign timeout_hit  = (TIMEOUT != 0) && (32'(cnt_q) == TIMEOUT - 1);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    f3_d       = f3_q;
    we_d       = we_q;
    rd_d       = rd_q;
    regwrite_d = regwrite_q;
    memtoreg_d = memtoreg_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    rdata_d    = rdata_q;
    wb_valid_d = 1'b0;
    wb_data_d  = wb_data_q;
    wb_rd_d    = wb_rd_q;
    wb_regwr_d = wb_regwr_q;
    err_addr_d = err_addr_q;
    err_cause  = ERR_NONE;
    stall      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (ex_valid) begin
          if (!is_mem) begin
            wb_valid_d = 1'b1;
            wb_data_d  = ex_result;
            wb_rd_d    = ex_rd_addr;
            wb_regwr_d = ex_regwrite;
          end else if (access_cause != ERR_NONE) begin
            err_cause  = access_cause;
            err_addr_d = ex_result;
            wb_valid_d = 1'b1;
            wb_rd_d    = ex_rd_addr;
            wb_regwr_d = 1'b0;
          end else begin
            stall      = 1'b1;
            state_d    = ST_BUSY;
            cnt_d      = '0;
            addr_d     = ex_result;
            f3_d       = ex_align[2:0];
            we_d       = ex_align[3];
            rd_d       = ex_rd_addr;
            regwrite_d = ex_regwrite;
            memtoreg_d = ex_memtoreg;
            case (ex_align[2:0])
              MEM_B: begin
                wstrb_d = 4'b0001 << ex_result[1:0];
                wdata_d = {4{ex_write_data[7:0]}};
              end
              MEM_H: begin
                wstrb_d = 4'b0011 << ex_result[1:0];
                wdata_d = {2{ex_write_data[15:0]}};
              end
              default: begin
                wstrb_d = 4'b1111;
                wdata_d = ex_write_data;
              end
            endcase
            if (!ex_align[3]) begin
              wstrb_d = '0;
              wdata_d = '0;
            end
          end
        end
      end

      ST_BUSY: begin
        stall = 1'b1;
        if (dmem_ack) begin
          if (we_q) begin
            state_d    = ST_IDLE;
            wb_valid_d = 1'b1;
            wb_rd_d    = rd_q;
            wb_regwr_d = 1'b0;
          end else begin
            rdata_d = dmem_rdata;
            state_d = ST_RESP;
          end
        end else if (timeout_hit) begin
          state_d    = ST_IDLE;
          err_cause  = ERR_TIMEOUT;
          err_addr_d = addr_q;
          wb_valid_d = 1'b1;
          wb_rd_d    = rd_q;
          wb_regwr_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_RESP: begin
        stall      = 1'b1;
        state_d    = ST_IDLE;
        wb_valid_d = 1'b1;
        wb_data_d  = memtoreg_q ? load_data : addr_q;
        wb_rd_d    = rd_q;
        wb_regwr_d = regwrite_q;
      end

      default: state_d = ST_IDLE;
    endcase

    mem_err_d = (err_cause != ERR_NONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      f3_q       <= '0;
      we_q       <= 1'b0;
      rd_q       <= '0;
      regwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      rdata_q    <= '0;
      wb_valid_q <= 1'b0;
      wb_data_q  <= '0;
      wb_rd_q    <= '0;
      wb_regwr_q <= 1'b0;
      mem_err_q  <= 1'b0;
      err_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      f3_q       <= f3_d;
      we_q       <= we_d;
      rd_q       <= rd_d;
      regwrite_q <= regwrite_d;
      memtoreg_q <= memtoreg_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      rdata_q    <= rdata_d;
      wb_valid_q <= wb_valid_d;
      wb_data_q  <= wb_data_d;
      wb_rd_q    <= wb_rd_d;
      wb_regwr_q <= wb_regwr_d;
      mem_err_q  <= mem_err_d;
      err_addr_q <= err_addr_d;
    end
  end

  // Bus outputs are gated by BUSY so they read zero whenever no request is live.
  assign dmem_req    = busy;
  assign dmem_we     = busy & we_q;
  assign dmem_addr   = busy ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign dmem_wdata  = busy ? wdata_q : '0;
  assign dmem_wstrb  = busy ? wstrb_q : '0;
  assign wb_valid    = wb_valid_q;
  assign wb_data     = wb_data_q;
  assign wb_rd_addr  = wb_rd_q;
  assign wb_regwrite = wb_regwr_q;
  assign mem_err     = mem_err_q;
  assign err_addr    = err_addr_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed plus randomized bench for mem_access_unit with a behavioural
// model of access legality, store lanes and load extension.
module tb_mem_access_unit;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic [31:0] ex_result;
  logic [31:0] ex_write_data;
  logic [3:0]  ex_align;
  logic        ex_memread, ex_memwrite, ex_memtoreg, ex_regwrite;
  logic [4:0]  ex_rd_addr;
  logic        stall;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;
  logic        wb_valid;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd_addr;
  logic        wb_regwrite;
  logic        mem_err;
  logic [31:0] err_addr;

  int checks   = 0;
  int failures = 0;

  mem_access_unit #(.TIMEOUT(TO), .ADDR_W(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .ex_valid      (ex_valid),
    .ex_result     (ex_result),
    .ex_write_data (ex_write_data),
    .ex_align      (ex_align),
    .ex_memread    (ex_memread),
    .ex_memwrite   (ex_memwrite),
    .ex_memtoreg   (ex_memtoreg),
    .ex_regwrite   (ex_regwrite),
    .ex_rd_addr    (ex_rd_addr),
    .stall         (stall),
    .dmem_req      (dmem_req),
    .dmem_we       (dmem_we),
    .dmem_addr     (dmem_addr),
    .dmem_wdata    (dmem_wdata),
    .dmem_wstrb    (dmem_wstrb),
    .dmem_rdata    (dmem_rdata),
    .dmem_ack      (dmem_ack),
    .wb_valid      (wb_valid),
    .wb_data       (wb_data),
    .wb_rd_addr    (wb_rd_addr),
    .wb_regwrite   (wb_regwrite),
    .mem_err       (mem_err),
    .err_addr      (err_addr)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    ex_valid      = 1'b0;
    ex_result     = '0;
    ex_write_data = '0;
    ex_align      = '0;
    ex_memread    = 1'b0;
    ex_memwrite   = 1'b0;
    ex_memtoreg   = 1'b0;
    ex_regwrite   = 1'b0;
    ex_rd_addr    = '0;
    dmem_ack      = 1'b0;
  endtask

  // Access size in bytes, 0 when the funct3 is not valid for the direction.
  function automatic int unsigned model_size(input bit st, input int unsigned f3);
    if (st) return (f3 == 0) ? 1 : (f3 == 1) ? 2 : (f3 == 2) ? 4 : 0;
    return (f3 == 0 || f3 == 4) ? 1 : (f3 == 1 || f3 == 5) ? 2 : (f3 == 2) ? 4 : 0;
  endfunction

  function automatic bit model_legal(input bit st, input int unsigned f3, input int unsigned addr);
    int unsigned sz;
    sz = model_size(st, f3);
    if (sz == 0) return 1'b0;
    return (addr % sz) == 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] rdata, input int unsigned addr,
                                             input int unsigned f3);
    int unsigned sh, v;
    sh = (addr % 4) * 8;
    case (f3)
      0: begin v = (rdata >> sh) & 32'hFF;   return (v >= 128)   ? v + 32'hFFFF_FF00 : v; end
      4: return (rdata >> sh) & 32'hFF;
      1: begin v = (rdata >> sh) & 32'hFFFF; return (v >= 32768) ? v + 32'hFFFF_0000 : v; end
      5: return (rdata >> sh) & 32'hFFFF;
      default: return rdata;
    endcase
  endfunction

  function automatic logic [31:0] model_wstrb(input int unsigned f3, input int unsigned addr);
    case (f3)
      0: return 32'd1 << (addr % 4);
      1: return 32'd3 << (addr % 4);
      default: return 32'd15;
    endcase
  endfunction

  function automatic logic [31:0] model_wdata(input int unsigned f3, input logic [31:0] wd);
    case (f3)
      0: return (wd & 32'hFF) * 32'h0101_0101;
      1: return (wd & 32'hFFFF) * 32'h0001_0001;
      default: return wd;
    endcase
  endfunction

  task automatic do_alu(input string tag, input logic [31:0] res, input logic [4:0] rd, input bit rw);
    ex_valid = 1'b1; ex_result = res; ex_align = '0; ex_memread = 1'b0; ex_memwrite = 1'b0;
    ex_memtoreg = 1'b0; ex_regwrite = rw; ex_rd_addr = rd; ex_write_data = $urandom;
    #1 check({tag, ":stall"}, stall, 0);
    tick();
    drive_idle();
    check({tag, ":wb_valid"}, wb_valid, 1);
    check({tag, ":wb_data"}, wb_data, res);
    check({tag, ":wb_rd"}, wb_rd_addr, rd);
    check({tag, ":wb_regwrite"}, wb_regwrite, rw);
    check({tag, ":req"}, dmem_req, 0);
    tick();
    check({tag, ":wb_pulse"}, wb_valid, 0);
  endtask

  // ack_at: BUSY cycle (1-based) on which ack is given; 0 = never (timeout).
  task automatic mem_op(input string tag, input bit st, input bit both, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rdata,
                        input int unsigned ack_at, input logic [4:0] rd);
    bit          legal, acked;
    int unsigned reqs;
    legal = !both && model_legal(st, f3, addr);
    ex_valid = 1'b1; ex_result = addr; ex_write_data = wd; ex_align = {st, f3};
    ex_memread = !st || both; ex_memwrite = st || both; ex_memtoreg = !st;
    ex_regwrite = !st; ex_rd_addr = rd;
    #1 check({tag, ":stall_accept"}, stall, legal);
    check({tag, ":req_accept"}, dmem_req, 0);
    tick();
    if (!legal) begin
      drive_idle();
      check({tag, ":err_pulse"}, mem_err, 1);
      check({tag, ":err_addr"}, err_addr, addr);
      check({tag, ":err_wb_valid"}, wb_valid, 1);
      check({tag, ":err_wb_regwrite"}, wb_regwrite, 0);
      check({tag, ":err_no_req"}, dmem_req, 0);
      #1 check({tag, ":err_stall"}, stall, 0);
      tick();
      check({tag, ":err_pulse_end"}, mem_err, 0);
      check({tag, ":err_wb_end"}, wb_valid, 0);
      return;
    end
    reqs  = 0;
    acked = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      reqs += dmem_req;
      check({tag, ":addr"}, dmem_addr, addr - (addr % 4));
      check({tag, ":we"}, dmem_we, st);
      if (st) begin
        check({tag, ":wstrb"}, dmem_wstrb, model_wstrb(f3, addr));
        check({tag, ":wdata"}, dmem_wdata, model_wdata(f3, wd));
      end
      // Upstream keeps presenting work while stalled; it must be ignored.
      ex_valid = 1'b1; ex_memread = 1'b0; ex_memwrite = 1'b0;
      ex_result = $urandom; ex_rd_addr = 5'($urandom); ex_regwrite = 1'b1;
      dmem_ack   = (c == ack_at);
      dmem_rdata = (c == ack_at) ? rdata : $urandom;
      #1 check({tag, ":stall_busy"}, stall, 1);
      tick();
      if (c == ack_at) begin
        acked = 1'b1;
        break;
      end
      if (ack_at == 0 && c == TO) break;
    end
    drive_idle();
    check({tag, ":req_cycles"}, reqs, (ack_at == 0) ? TO : ack_at);
    check({tag, ":req_dropped"}, dmem_req, 0);
    if (!acked) begin
      check({tag, ":to_err"}, mem_err, 1);
      check({tag, ":to_err_addr"}, err_addr, addr);
      check({tag, ":to_wb_valid"}, wb_valid, 1);
      check({tag, ":to_wb_regwrite"}, wb_regwrite, 0);
      dmem_ack = 1'b1;
      dmem_rdata = $urandom;
      tick();
      dmem_ack = 1'b0;
      check({tag, ":late_ack_req"}, dmem_req, 0);
      check({tag, ":late_ack_wb"}, wb_valid, 0);
      check({tag, ":late_ack_err"}, mem_err, 0);
      #1 check({tag, ":late_ack_stall"}, stall, 0);
      return;
    end
    if (st) begin
      check({tag, ":st_wb_valid"}, wb_valid, 1);
      check({tag, ":st_wb_regwrite"}, wb_regwrite, 0);
      check({tag, ":st_wb_rd"}, wb_rd_addr, rd);
      check({tag, ":st_err"}, mem_err, 0);
      #1 check({tag, ":st_stall"}, stall, 0);
    end else begin
      check({tag, ":resp_wb"}, wb_valid, 0);
      #1 check({tag, ":resp_stall"}, stall, 1);
      tick();
      check({tag, ":ld_wb_valid"}, wb_valid, 1);
      check({tag, ":ld_wb_data"}, wb_data, model_load(rdata, addr, f3));
      check({tag, ":ld_wb_rd"}, wb_rd_addr, rd);
      check({tag, ":ld_wb_regwrite"}, wb_regwrite, 1);
      check({tag, ":ld_err"}, mem_err, 0);
      check({tag, ":ld_stall"}, stall, 0);
    end
    tick();
    check({tag, ":wb_pulse_end"}, wb_valid, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ":stall"}, stall, 0);
    check({tag, ":req"}, dmem_req, 0);
    check({tag, ":we"}, dmem_we, 0);
    check({tag, ":addr"}, dmem_addr, 0);
    check({tag, ":wdata"}, dmem_wdata, 0);
    check({tag, ":wstrb"}, dmem_wstrb, 0);
    check({tag, ":wb_valid"}, wb_valid, 0);
    check({tag, ":wb_data"}, wb_data, 0);
    check({tag, ":wb_rd"}, wb_rd_addr, 0);
    check({tag, ":wb_regwrite"}, wb_regwrite, 0);
    check({tag, ":mem_err"}, mem_err, 0);
    check({tag, ":err_addr"}, err_addr, 0);
  endtask

  initial begin
    logic [31:0] a, wd, rd_word;
    logic [2:0]  f3;
    bit          st, both;
    int unsigned kind, dly;

    rst = 1'b1;
    drive_idle();
    dmem_rdata = '0;
    repeat (3) tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();

    do_alu("alu", 32'h0000_1234, 5'd5, 1'b1);
    mem_op("sb", 1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0000_00AB, '0, 2, 5'd0);
    mem_op("lb", 1'b0, 1'b0, 3'b000, 32'h0000_0201, '0, 32'h1122_8033, 1, 5'd7);
    mem_op("lbu", 1'b0, 1'b0, 3'b100, 32'h0000_0201, '0, 32'h1122_8033, 1, 5'd8);
    mem_op("lh", 1'b0, 1'b0, 3'b001, 32'h0000_0202, '0, 32'h1122_8033, 1, 5'd9);
    mem_op("lhu_neg", 1'b0, 1'b0, 3'b101, 32'h0000_0200, '0, 32'h1122_8033, 3, 5'd10);
    mem_op("sh_hi", 1'b1, 1'b0, 3'b001, 32'h0000_0302, 32'hDEAD_BEEF, '0, 1, 5'd0);
    mem_op("sw", 1'b1, 1'b0, 3'b010, 32'h0000_0400, 32'hCAFE_F00D, '0, 3, 5'd0);
    mem_op("lw_misalign", 1'b0, 1'b0, 3'b010, 32'h0000_0106, '0, '0, 1, 5'd3);
    mem_op("sh_misalign", 1'b1, 1'b0, 3'b001, 32'h0000_0101, 32'h1, '0, 1, 5'd0);
    mem_op("ld_f3_illegal", 1'b0, 1'b0, 3'b011, 32'h0000_0100, '0, '0, 1, 5'd4);
    mem_op("st_f3_illegal", 1'b1, 1'b0, 3'b100, 32'h0000_0100, 32'h5, '0, 1, 5'd0);
    mem_op("rd_and_wr", 1'b0, 1'b1, 3'b010, 32'h0000_0100, '0, '0, 1, 5'd6);
    mem_op("timeout", 1'b0, 1'b0, 3'b010, 32'h0000_0500, '0, 32'h1234_5678, 0, 5'd11);
    mem_op("ack_at_limit", 1'b0, 1'b0, 3'b010, 32'h0000_0504, '0, 32'h8765_4321, TO, 5'd12);

    // Reset while a load is outstanding.
    ex_valid = 1'b1; ex_result = 32'h0000_0600; ex_align = 4'b0010; ex_memread = 1'b1;
    ex_memtoreg = 1'b1; ex_regwrite = 1'b1; ex_rd_addr = 5'd13;
    tick();
    drive_idle();
    tick();
    check("rst_mid:req_before", dmem_req, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_all_zero("rst_mid");
    dmem_ack = 1'b1;
    dmem_rdata = 32'hFFFF_FFFF;
    tick();
    dmem_ack = 1'b0;
    check("rst_mid:late_ack_wb", wb_valid, 0);
    check("rst_mid:late_ack_req", dmem_req, 0);
    do_alu("alu_after_rst", 32'hA5A5_0001, 5'd31, 1'b1);

    for (int i = 0; i < 40; i++) begin
      kind    = $urandom_range(0, 3);
      st      = 1'($urandom_range(0, 1));
      f3      = 3'($urandom_range(0, 7));
      a       = 32'h0000_1000 + $urandom_range(0, 63);
      wd      = $urandom;
      rd_word = $urandom;
      dly     = $urandom_range(1, 3);
      both    = ($urandom_range(0, 15) == 0);
      if (kind == 0) begin
        do_alu("rand_alu", $urandom, 5'($urandom), 1'($urandom));
      end else begin
        if (kind == 1) f3 = st ? 3'($urandom_range(0, 2)) : 3'b000;
        mem_op(st ? "rand_st" : "rand_ld", st, both, f3, a, wd, rd_word, dly, 5'($urandom));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
